// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a PC through program memory and buffers
// {pc, instr} pairs in a 2-entry FIFO, with branch redirect and halt/resume.
//
// state  | meaning
// IDLE   | out of reset, waiting for start; branches ignored
// FETCH  | pushing one instruction per cycle while the FIFO has room
// HALTED | fetch suspended, PC frozen, queued entries still drain
module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       halt,
  output logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic [1:0] fifo_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t     state, state_nxt;
  logic [7:0] pc;
  logic [7:0] head_pc, head_instr;
  logic [7:0] tail_pc, tail_instr;
  logic [1:0] count;
  logic       pop, push, flush;

  assign prog_addr   = pc;
  assign instr       = head_instr;
  assign instr_pc    = head_pc;
  assign instr_valid = (count != 2'd0);
  assign fifo_count  = count;

  assign pop   = instr_valid & instr_ready;
  assign flush = branch_valid & (state != IDLE);
  // A full FIFO can still accept a push when the head leaves on the same edge.
  assign push  = (state == FETCH) & ~halt & ~branch_valid & ((count < 2'd2) | pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !halt) state_nxt = FETCH;
      FETCH:   if (halt)           state_nxt = HALTED;
      HALTED:  if (start && !halt) state_nxt = FETCH;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= RESET_PC;
    else if (flush) pc <= branch_target;
    else if (push)  pc <= pc + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_pc    <= 8'h00;
      head_instr <= 8'h00;
      tail_pc    <= 8'h00;
      tail_instr <= 8'h00;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc    <= pc;
            head_instr <= prog_data;
          end else begin
            tail_pc    <= pc;
            tail_instr <= prog_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc    <= pc;
            head_instr <= prog_data;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= pc;
            tail_instr <= prog_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected {pc, instr}
// pairs, a negedge monitor compares every accepted instruction against them.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       branch_valid = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic [1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic        mon_en = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  assign prog_data = prog_addr ^ 8'hA5;

  instr_fetch #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_valid(branch_valid),
    .branch_target(branch_target), .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A pop on the coming edge is visible now; branch cycles discard the pop.
  always @(negedge clk) begin
    if (mon_en && instr_valid && instr_ready && !branch_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("mon_instr_pc", instr_pc, e[15:8]);
        chk("mon_instr", instr, e[7:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [7:0] first_pc, input int n);
    logic [7:0] p;
    p = first_pc;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, p ^ 8'hA5});
      p = p + 8'd1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
    end
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    start = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 8'h00;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst_valid", {7'd0, instr_valid}, 8'h00);
    chk("rst_count", {6'd0, fifo_count}, 8'h00);
    chk("rst_instr", instr, 8'h00);
    chk("rst_instr_pc", instr_pc, 8'h00);
    chk("rst_pc", prog_addr, 8'h00);
    step(3);
    chk("idle_hold_valid", {7'd0, instr_valid}, 8'h00);

    // Streaming with ready=1; a branch in IDLE alongside start is ignored
    instr_ready = 1'b1;
    mon_en = 1'b1;
    expect_seq(8'h00, 8);
    start = 1'b1; branch_valid = 1'b1; branch_target = 8'h80;
    step(1);
    start = 1'b0; branch_valid = 1'b0;
    chk("first_cycle_empty", {6'd0, fifo_count}, 8'h00);
    step(1);
    chk("first_push_valid", {7'd0, instr_valid}, 8'h01);
    drain("stream", 20);

    // Back-pressure saturates at 2 entries, then in-order drain
    do_reset();
    pulse_start();
    step(5);
    chk("sat_count", {6'd0, fifo_count}, 8'h02);
    chk("sat_pc", prog_addr, 8'h02);
    chk("sat_head_pc", instr_pc, 8'h00);
    chk("sat_head_instr", instr, 8'hA5);
    mon_en = 1'b1;
    expect_seq(8'h00, 6);
    instr_ready = 1'b1;
    drain("backpressure", 20);

    // Branch while full flushes stale entries
    do_reset();
    pulse_start();
    step(4);
    mon_en = 1'b1;
    expect_seq(8'h40, 4);
    instr_ready = 1'b1; branch_valid = 1'b1; branch_target = 8'h40;
    step(1);
    branch_valid = 1'b0;
    chk("branch_flush_count", {6'd0, fifo_count}, 8'h00);
    step(1);
    chk("branch_target_pc", instr_pc, 8'h40);
    drain("branch", 20);

    // PC wrap FE, FF, 00, 01
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    mon_en = 1'b1;
    expect_seq(8'hFE, 4);
    branch_valid = 1'b1; branch_target = 8'hFE;
    step(1);
    branch_valid = 1'b0;
    drain("wrap", 20);

    // Halt with 2 queued: both drain, PC frozen, start+halt ignored, resume
    do_reset();
    pulse_start();
    step(4);
    mon_en = 1'b1;
    expect_seq(8'h00, 2);
    halt = 1'b1; instr_ready = 1'b1;
    drain("halt_drain", 10);
    step(3);
    chk("halt_valid", {7'd0, instr_valid}, 8'h00);
    chk("halt_pc", prog_addr, 8'h02);
    pulse_start();
    step(2);
    chk("start_halt_valid", {7'd0, instr_valid}, 8'h00);
    chk("start_halt_pc", prog_addr, 8'h02);
    halt = 1'b0;
    mon_en = 1'b1;
    expect_seq(8'h02, 3);
    pulse_start();
    drain("resume", 20);

    // Asynchronous reset between edges while full
    do_reset();
    pulse_start();
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", {6'd0, fifo_count}, 8'h00);
    chk("async_valid", {7'd0, instr_valid}, 8'h00);
    chk("async_instr", instr, 8'h00);
    chk("async_instr_pc", instr_pc, 8'h00);
    chk("async_pc", prog_addr, 8'h00);
    step(1);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    step(3);
    chk("post_rst_idle_valid", {7'd0, instr_valid}, 8'h00);
    chk("post_rst_idle_pc", prog_addr, 8'h00);
    mon_en = 1'b1;
    expect_seq(8'h00, 3);
    pulse_start();
    drain("post_rst", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
